// File: rtl/traffic_controller_pkg.sv
// Shared lamp encodings, controller state set and a small elaboration helper.
package traffic_controller_pkg;

   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] YEL = 2'b01;
   localparam logic [1:0] GRN = 2'b10;

   typedef enum logic [2:0] {
      MAIN_GRN,
      MAIN_EXT,
      MAIN_YEL,
      WALK,
      SIDE_GRN,
      SIDE_EXT,
      SIDE_YEL,
      FLASH
   } state_t;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/traffic_controller_tick_gen.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; tick is high while the
// count sits at TICK_DIV-1 and is held low during reset.
module tick_gen #(
   parameter int TICK_DIV = 100000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   always_comb begin
      wrap  = (cnt_q == LAST);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // With TICK_DIV=1 the count never leaves 0, so tick is only suppressed by reset.
   assign tick = wrap & ~rst;

endmodule

// File: rtl/traffic_controller.sv
// Intersection controller: main/side greens with sensor extension, pedestrian walk
// phase and night flash; lamp outputs are registered from the next state.
module traffic_controller
   import traffic_controller_pkg::*;
#(
   parameter int TICK_DIV = 100000000,
   parameter int T_BASE   = 6,
   parameter int T_EXT    = 3,
   parameter int T_YEL    = 2,
   parameter int T_WALK   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Sensor,
   input  logic       walkButton,
   input  logic       flash,
   output logic [1:0] mainLight,
   output logic [1:0] sideLight,
   output logic       walkLight,
   output logic       tick
);

   localparam int T_MAX = max4(T_BASE, T_EXT, T_YEL, T_WALK);
   localparam int TW    = $clog2(T_MAX + 1);

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, last_t;
   logic          walk_q, walk_d;
   logic [1:0]    main_q, main_d, side_q, side_d;
   logic          walk_lamp_q, walk_lamp_d;
   logic          tick_w, done;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_w)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         MAIN_EXT, SIDE_EXT: last_t = TW'(T_EXT - 1);
         MAIN_YEL, SIDE_YEL: last_t = TW'(T_YEL - 1);
         WALK:               last_t = TW'(T_WALK - 1);
         default:            last_t = TW'(T_BASE - 1);
      endcase
      done = tick_w && (timer_q == last_t);

      if (tick_w && flash) begin
         state_d = FLASH;
      end else if (state_q == FLASH) begin
         if (tick_w) state_d = MAIN_GRN;
      end else if (done) begin
         case (state_q)
            MAIN_GRN: state_d = Sensor ? MAIN_EXT : MAIN_YEL;
            MAIN_EXT: state_d = MAIN_YEL;
            MAIN_YEL: state_d = walk_q ? WALK : SIDE_GRN;
            WALK:     state_d = SIDE_GRN;
            SIDE_GRN: state_d = Sensor ? SIDE_EXT : SIDE_YEL;
            SIDE_EXT: state_d = SIDE_YEL;
            SIDE_YEL: state_d = MAIN_GRN;
            default:  state_d = MAIN_GRN;
         endcase
      end

      if (state_d != state_q) timer_d = '0;
      else if (tick_w)        timer_d = timer_q + 1'b1;
      else                    timer_d = timer_q;

      // A press on the WALK entry cycle re-arms the request for the next round.
      walk_d = walkButton | (walk_q & ~((state_d == WALK) && (state_q != WALK)));

      main_d      = RED;
      side_d      = RED;
      walk_lamp_d = 1'b0;
      case (state_d)
         MAIN_GRN, MAIN_EXT: main_d = GRN;
         MAIN_YEL:           main_d = YEL;
         WALK:               walk_lamp_d = 1'b1;
         SIDE_GRN, SIDE_EXT: side_d = GRN;
         SIDE_YEL:           side_d = YEL;
         FLASH:              main_d = timer_d[0] ? RED : YEL;
         default:            main_d = RED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= MAIN_GRN;
         timer_q     <= '0;
         walk_q      <= 1'b0;
         main_q      <= GRN;
         side_q      <= RED;
         walk_lamp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         walk_q      <= walk_d;
         main_q      <= main_d;
         side_q      <= side_d;
         walk_lamp_q <= walk_lamp_d;
      end
   end

   assign mainLight = main_q;
   assign sideLight = side_q;
   assign walkLight = walk_lamp_q;
   assign tick      = tick_w;

endmodule

// File: doc/traffic_controller.md
TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, sampled on the rising edge; rst input 1, synchronous active-high reset.
REQ-002 Parameter TICK_DIV SHALL default to 100000000 and set the clk cycles per timing tick (value 1 allowed).
REQ-003 Parameter T_BASE SHALL default to 6 and set the base green duration in ticks, main and side.
REQ-004 Parameter T_EXT SHALL default to 3 and set the green extension in ticks when traffic is sensed.
REQ-005 Parameter T_YEL SHALL default to 2 and set the yellow duration in ticks.
REQ-006 Parameter T_WALK SHALL default to 3 and set the walk duration in ticks.
REQ-007 Input Sensor SHALL be 1 bit: side-street traffic present, level.
REQ-008 Input walkButton SHALL be 1 bit: pedestrian request, any pulse width of at least 1 clk.
REQ-009 Input flash SHALL be 1 bit: night flash mode request, level.
REQ-010 Output mainLight SHALL be 2 bits: main-street lamp, encoded 00 red, 01 yellow, 10 green.
REQ-011 Output sideLight SHALL be 2 bits: side-street lamp, using the same encoding.
REQ-012 Output walkLight SHALL be 1 bit: walk lamp on.
REQ-013 Output tick SHALL be 1 bit: one-clk pulse marking each timing tick, for observation.

Function
REQ-014 The tick counter SHALL count 0..TICK_DIV-1, and tick SHALL be high during the cycle in which the count equals TICK_DIV-1, wrapping to 0 on the next cycle.
REQ-015 States SHALL be MAIN_GRN, MAIN_EXT, MAIN_YEL, WALK, SIDE_GRN, SIDE_EXT, SIDE_YEL, FLASH.
REQ-016 Outputs SHALL be registered and decoded from state, with the lamp values fixed per state:
- MAIN_GRN/MAIN_EXT: main=10, side=00.
- MAIN_YEL: main=01, side=00.
- WALK: both 00, walkLight=1.
- SIDE_GRN/SIDE_EXT: main=00, side=10.
- SIDE_YEL: main=00, side=01.
REQ-017 A tick timer SHALL clear on state entry and advance on each tick; a timed state SHALL exit on the tick where timer equals its duration-1, so each state lasts exactly its duration in ticks.
REQ-018 MAIN_GRN SHALL exit as follows: if Sensor=1 on the exit tick, go to MAIN_EXT (T_EXT ticks); otherwise go to MAIN_YEL.
REQ-019 MAIN_EXT SHALL go to MAIN_YEL on its exit tick.
REQ-020 MAIN_YEL SHALL exit to WALK if the walk request latch is set, otherwise to SIDE_GRN.
REQ-021 WALK SHALL go to SIDE_GRN.
REQ-022 SIDE_GRN SHALL exit to SIDE_EXT if Sensor=1 on the exit tick, otherwise to SIDE_YEL; SIDE_EXT SHALL go to SIDE_YEL; SIDE_YEL SHALL go to MAIN_GRN.
REQ-023 The walk request latch SHALL set on any clk where walkButton=1, and clear on the clk where WALK is entered.
REQ-024 A walkButton press during WALK SHALL set the latch again, so the request is served on the next cycle.
REQ-025 If set and clear of the walk latch coincide, set SHALL win.
REQ-026 When flash=1 on a tick, the FSM SHALL enter FLASH from any state, including mid-WALK, on that tick.
REQ-027 In FLASH: side=00, walkLight=0, and main SHALL alternate 01/00 starting at 01 on entry and toggling each tick.
REQ-028 When flash=0 on a tick while in FLASH, the FSM SHALL go to MAIN_GRN with the timer cleared.
REQ-029 The walk latch SHALL be retained through FLASH.
REQ-030 The timer width SHALL be clog2 of the maximum duration plus 1, and the tick counter width SHALL be clog2(TICK_DIV) (minimum 1).
REQ-031 Every duration parameter SHALL be at least 1.

Reset
REQ-032 On rst=1 at a clk edge: state=MAIN_GRN, timer=0, tick counter=0, walk latch=0, mainLight=10, sideLight=00, walkLight=0, tick=0.
REQ-033 Reset SHALL override all inputs, including flash, and mid-operation reset SHALL restart a full MAIN_GRN period.

Structure
REQ-034 A shared package SHALL hold the lamp encodings (RED, YEL, GRN) and the state enumeration.
REQ-035 One sub-module, tick_gen, SHALL be instantiated: parameter TICK_DIV, inputs clk/rst, output tick.

Verification
REQ-036 The bench SHALL use TICK_DIV=4 with defaults elsewhere and cover these scenarios:
- Sensor=0, no walk: main green 24 clk, yellow 8, side green 24, side yellow 8, repeat.
- Sensor=1 held: main green 36 clk (24+12), side green 36.
- walkButton pulsed 1 clk during MAIN_GRN: after MAIN_YEL, walkLight=1 for 12 clk with both lamps 00, then SIDE_GRN.
- flash=1 asserted mid-SIDE_GRN: at the next tick side=00 and main toggles 01/00 every 4 clk; on deassert, MAIN_GRN for 24 clk.
- rst pulsed mid-WALK: next cycle main=10, walkLight=0, walk latch=0, tick counter restarts at 0.
- TICK_DIV=1: states last exactly their duration in clk, and tick is constantly 1 after reset.
